// File: rtl/mem_arbiter_if.sv
// Shared memory port bundle: I-cache side, D-cache side and the downstream
// slow-memory port. The arbiter takes the slave view.
interface mem_arbiter_if #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
);
    logic              i_read;
    logic              i_write;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_wdata;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ready;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport slave (
        input  i_read, i_write, i_addr, i_wdata,
        output i_rdata, i_ready,
        input  d_read, d_write, d_addr, d_wdata,
        output d_rdata, d_ready,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport master (
        output i_read, i_write, i_addr, i_wdata,
        input  i_rdata, i_ready,
        output d_read, d_write, d_addr, d_wdata,
        input  d_rdata, d_ready,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mem_arbiter.sv
// I/D cache arbiter onto one slow-memory port with saturating per-side counters.
// Define ARB_ROUND_ROBIN_EN for round-robin tie breaking (default: D over I).
module mem_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_arbiter_if.slave     bus,
    output logic [CNT_W-1:0] i_cnt,
    output logic [CNT_W-1:0] d_cnt,
    output logic             busy
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] i_cnt_q, i_cnt_d;
    logic [CNT_W-1:0] d_cnt_q, d_cnt_d;
    logic             busy_q, busy_d;
    logic             i_pend, d_pend, pick_d;

    assign i_pend = bus.i_read | bus.i_write;
    assign d_pend = bus.d_read | bus.d_write;

`ifdef ARB_ROUND_ROBIN_EN
    // last_d_q: 1 when D was granted most recently
    logic last_d_q, last_d_d;
    assign pick_d   = d_pend & (~i_pend | ~last_d_q);
    assign last_d_d = (state_q == IDLE && (i_pend | d_pend)) ? pick_d : last_d_q;
`else
    assign pick_d = d_pend;
`endif

    always_comb begin
        state_d = state_q;
        i_cnt_d = i_cnt_q;
        d_cnt_d = d_cnt_q;
        unique case (state_q)
            GNT_I: begin
                if (bus.mem_ready) begin
                    state_d = IDLE;
                    if (i_cnt_q != '1) i_cnt_d = i_cnt_q + CNT_W'(1);
                end else if (!i_pend) begin
                    state_d = IDLE;
                end
            end
            GNT_D: begin
                if (bus.mem_ready) begin
                    state_d = IDLE;
                    if (d_cnt_q != '1) d_cnt_d = d_cnt_q + CNT_W'(1);
                end else if (!d_pend) begin
                    state_d = IDLE;
                end
            end
            default: begin
                if (pick_d)      state_d = GNT_D;
                else if (i_pend) state_d = GNT_I;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            i_cnt_q  <= '0;
            d_cnt_q  <= '0;
            busy_q   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_d_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            i_cnt_q  <= i_cnt_d;
            d_cnt_q  <= d_cnt_d;
            busy_q   <= busy_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_d_q <= last_d_d;
`endif
        end
    end

    always_comb begin
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.i_ready   = 1'b0;
        bus.d_ready   = 1'b0;
        unique case (state_q)
            GNT_I: begin
                bus.mem_read  = bus.i_read;
                bus.mem_write = bus.i_write;
                bus.mem_addr  = bus.i_addr;
                bus.mem_wdata = bus.i_wdata;
                bus.i_ready   = bus.mem_ready;
            end
            GNT_D: begin
                bus.mem_read  = bus.d_read;
                bus.mem_write = bus.d_write;
                bus.mem_addr  = bus.d_addr;
                bus.mem_wdata = bus.d_wdata;
                bus.d_ready   = bus.mem_ready;
            end
            default: ;
        endcase
    end

    assign bus.i_rdata = bus.mem_rdata;
    assign bus.d_rdata = bus.mem_rdata;
    assign i_cnt = i_cnt_q;
    assign d_cnt = d_cnt_q;
    assign busy  = busy_q;
endmodule
